// File: rtl/mito_pool_pkg.sv
// Shared types and helpers for the max-pool collator.
package mito_pool_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_LANES      = 4;
  localparam int unsigned DEF_WIN_MAX    = 4;

  typedef logic signed [DEF_DATA_WIDTH-1:0] lane_t;

  // Window accumulation phase; the pending-output (EMIT) phase is out_valid itself.
  typedef enum logic {
    ACCUM_EMPTY = 1'b0,
    ACCUM_PART  = 1'b1
  } state_e;

  // Window length 0 behaves as 1, anything above win_max saturates.
  function automatic int unsigned clamp_win(input int unsigned win, input int unsigned win_max);
    if (win == 0) return 1;
    if (win > win_max) return win_max;
    return win;
  endfunction

  // Negative values clamp to zero.
  function automatic lane_t relu(input lane_t v);
    return v[DEF_DATA_WIDTH-1] ? lane_t'(0) : v;
  endfunction

endpackage

// File: rtl/max_lane.sv
// One lane's signed running-maximum accumulator.
module max_lane
  import mito_pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         first_i,
  input  logic                         fold_i,
  input  logic signed [DATA_WIDTH-1:0] in_i,
  output logic signed [DATA_WIDTH-1:0] max_c
);

  logic signed [DATA_WIDTH-1:0] acc_q;
  logic signed [DATA_WIDTH-1:0] acc_d;

  // Max including the current beat; a first beat restarts from the input, ties keep acc.
  always_comb begin
    max_c = acc_q;
    if (first_i || (in_i > acc_q)) begin
      max_c = in_i;
    end
  end

  // Accumulator advances only on accepted beats.
  always_comb begin
    acc_d = acc_q;
    if (fold_i) begin
      acc_d = max_c;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/maxpool_collator.sv
// Streaming multi-lane signed max-pool: folds a window of beats into one output beat.
module maxpool_collator
  import mito_pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned WIN_MAX    = DEF_WIN_MAX,
  localparam int unsigned CNT_W     = $clog2(WIN_MAX + 1),
  localparam int unsigned BUS_W     = LANES * DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CNT_W-1:0] cfg_win,
  input  logic             cfg_relu,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [CNT_W-1:0]     win_l_q, win_l_d;
  logic                 relu_l_q, relu_l_d;
  logic                 out_valid_q, out_valid_d;
  logic [BUS_W-1:0]     out_data_q, out_data_d;
  logic [CNT_W-1:0]     out_count_q, out_count_d;

  logic                 accept_c;
  logic                 first_c;
  logic [CNT_W-1:0]     win_cfg_c;
  logic [CNT_W-1:0]     win_eff_c;
  logic                 relu_eff_c;
  logic [CNT_W-1:0]     count_inc_c;
  logic                 complete_c;
  logic [LANES-1:0][DATA_WIDTH-1:0] lane_max_c;

  // A stalled result blocks every input beat.
  assign in_ready    = !(out_valid_q && !out_ready);
  assign accept_c    = in_valid && in_ready;
  assign first_c     = (state_q == ACCUM_EMPTY);
  assign win_cfg_c   = CNT_W'(clamp_win(32'(cfg_win), WIN_MAX));
  assign win_eff_c   = first_c ? win_cfg_c : win_l_q;
  assign relu_eff_c  = first_c ? cfg_relu : relu_l_q;
  assign count_inc_c = count_q + CNT_W'(1);
  assign complete_c  = accept_c && ((count_inc_c == win_eff_c) || in_last);

  // Per-lane accumulators.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    max_lane #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_max_lane (
      .clk     (clk),
      .rst_n   (rst_n),
      .first_i (first_c),
      .fold_i  (accept_c),
      .in_i    (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .max_c   (lane_max_c[g])
    );
  end

  // Next-state: window phase, beat count and latched config.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    win_l_d  = win_l_q;
    relu_l_d = relu_l_q;
    if (accept_c) begin
      if (first_c) begin
        win_l_d  = win_cfg_c;
        relu_l_d = cfg_relu;
      end
      if (complete_c) begin
        state_d = ACCUM_EMPTY;
        count_d = '0;
      end else begin
        state_d = ACCUM_PART;
        count_d = count_inc_c;
      end
    end
  end

  // Output register next-state: load on completion, drop valid on a bare consume.
  always_comb begin
    logic [DATA_WIDTH-1:0] lane_v;
    lane_v      = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    if (complete_c) begin
      out_valid_d = 1'b1;
      out_count_d = count_inc_c;
      for (int unsigned i = 0; i < LANES; i++) begin
        lane_v = lane_max_c[i];
        if (relu_eff_c && lane_v[DATA_WIDTH-1]) begin
          lane_v = '0;
        end
        out_data_d[i*DATA_WIDTH +: DATA_WIDTH] = lane_v;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM_EMPTY;
      count_q     <= '0;
      win_l_q     <= CNT_W'(1);
      relu_l_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      win_l_q     <= win_l_d;
      relu_l_q    <= relu_l_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_maxpool_collator.sv
// Directed bench for maxpool_collator (8-bit lanes, 4 lanes, WIN_MAX 4).
module tb_maxpool_collator;

  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CW-1:0] cfg_win;
  logic          cfg_relu;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [CW-1:0] out_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  maxpool_collator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_win   (cfg_win),
    .cfg_relu  (cfg_relu),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  // Single comparison point.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {8'(l3), 8'(l2), 8'(l1), 8'(l0)};
  endfunction

  // Present one beat at a negedge, wait for acceptance, return at the next negedge.
  task automatic push(input logic [31:0] d, input logic last);
    int n;
    n        = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("push_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] d, input int cnt);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"},  out_data, d);
    chk({tag, "_count"}, 32'(out_count), 32'(cnt));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    int sent, got, cyc;

    rst_n     = 1'b0;
    cfg_win   = 3'd1;
    cfg_relu  = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data",  out_data,       32'd0);
    chk("rst_count", 32'(out_count), 32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 4-beat window, extremes in lane3.
    cfg_win = 3'd4; cfg_relu = 1'b0;
    push(pk(3, 1, -1, -128), 1'b0);
    push(pk(-7, 2, -1, 127), 1'b0);
    push(pk(12, 3, -1, 0), 1'b0);
    chk("basic_mid_valid", 32'(out_valid), 32'd0);
    push(pk(5, 4, -1, 0), 1'b0);
    check_out("basic", pk(12, 4, -1, 127), 4);
    @(negedge clk);
    chk("basic_one_cycle", 32'(out_valid), 32'd0);

    // All-negative with and without ReLU.
    cfg_win = 3'd2; cfg_relu = 1'b1;
    push(pk(-128, -5, 3, 0), 1'b0);
    push(pk(-1, -2, -4, 0), 1'b0);
    check_out("relu_on", pk(0, 0, 3, 0), 2);
    @(negedge clk);
    cfg_relu = 1'b0;
    push(pk(-128, -5, 3, 0), 1'b0);
    push(pk(-1, -2, -4, 0), 1'b0);
    check_out("relu_off", pk(-1, -2, 3, 0), 2);
    @(negedge clk);

    // Early close, then a fresh window of 1.
    cfg_win = 3'd4;
    push(pk(9, 0, 0, 0), 1'b0);
    push(pk(4, 0, 0, 0), 1'b1);
    check_out("early", pk(9, 0, 0, 0), 2);
    @(negedge clk);
    cfg_win = 3'd1;
    push(pk(1, 0, 0, 0), 1'b0);
    check_out("win1", pk(1, 0, 0, 0), 1);
    @(negedge clk);
    cfg_win = 3'd4; cfg_relu = 1'b1;
    push(pk(-3, 5, 0, 0), 1'b1);
    check_out("last_first", pk(0, 5, 0, 0), 1);
    @(negedge clk);

    // Config clamping and mid-window changes.
    cfg_win = 3'd0; cfg_relu = 1'b0;
    push(pk(7, 7, 7, 7), 1'b0);
    check_out("cfg0", pk(7, 7, 7, 7), 1);
    @(negedge clk);
    cfg_win = 3'd7;
    push(pk(1, 0, 0, 0), 1'b0);
    push(pk(2, 0, 0, 0), 1'b0);
    push(pk(3, 0, 0, 0), 1'b0);
    chk("cfg7_mid_valid", 32'(out_valid), 32'd0);
    push(pk(4, 0, 0, 0), 1'b0);
    check_out("cfg7", pk(4, 0, 0, 0), 4);
    @(negedge clk);
    cfg_win = 3'd3; cfg_relu = 1'b0;
    push(pk(-5, 0, 0, 0), 1'b0);
    cfg_win = 3'd1; cfg_relu = 1'b1;
    push(pk(-6, 0, 0, 0), 1'b0);
    chk("cfgchg_mid_valid", 32'(out_valid), 32'd0);
    push(pk(-9, 0, 0, 0), 1'b0);
    check_out("cfgchg", pk(-5, 0, 0, 0), 3);
    @(negedge clk);

    // Backpressure: stalled result blocks input and holds data.
    cfg_win = 3'd2; cfg_relu = 1'b0; out_ready = 1'b0;
    push(pk(1, 0, 0, 0), 1'b0);
    push(pk(2, 0, 0, 0), 1'b0);
    check_out("bp", pk(2, 0, 0, 0), 2);
    chk("bp_ready_low", 32'(in_ready), 32'd0);
    in_valid = 1'b1; in_data = pk(50, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("bp_hold_data",  out_data,       pk(2, 0, 0, 0));
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_ready", 32'(in_ready),  32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_same_cycle", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("bp_consumed_valid", 32'(out_valid), 32'd0);
    chk("bp_consumed_data",  out_data,       pk(2, 0, 0, 0));
    in_data = pk(60, 0, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check_out("bp_next", pk(60, 0, 0, 0), 2);
    @(negedge clk);

    // Scoreboard: 20 beats with random gaps and random out_ready, window of 1.
    cfg_win = 3'd1; cfg_relu = 1'b0;
    sent = 0; got = 0; cyc = 0;
    while (got < 20 && cyc < 400) begin
      out_ready = ($urandom_range(0, 2) != 0);
      if (!in_valid && sent < 20 && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b1;
        in_data  = pk(sent + 10, sent + 20, -(sent + 1), sent);
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          exp_v = exp_q.pop_front();
          chk("sb_data", out_data, exp_v);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
        @(negedge clk);
        in_valid = 1'b0;
      end else begin
        @(negedge clk);
      end
      cyc++;
    end
    chk("sb_count", 32'(got), 32'd20);
    chk("sb_sent",  32'(sent), 32'd20);
    out_ready = 1'b1;
    @(negedge clk);

    // Async reset in the middle of a window.
    cfg_win = 3'd4;
    push(pk(100, 100, 100, 100), 1'b0);
    in_valid = 1'b1; in_data = pk(90, 90, 90, 90);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_data",  out_data,       32'd0);
    chk("arst_count", 32'(out_count), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push(pk(1, -1, 5, 0), 1'b0);
    push(pk(2, -2, 5, 0), 1'b0);
    push(pk(3, -3, 5, 0), 1'b0);
    chk("arst_mid_valid", 32'(out_valid), 32'd0);
    push(pk(4, -4, 5, 0), 1'b0);
    check_out("arst_clean", pk(4, -1, 5, 0), 4);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
